uart_rx_fifo: RTL

Parametrised UART receiver with oversampled start detection, configurable frame format (data width, parity, stop bits) and an integrated receive FIFO with sticky error flags. It is the next-generation replacement for the fixed 8N1 single-register receiver. It sits between the asynchronous `RxD` pin and the bus-side register interface, which drains bytes through a first-word-fall-through pop port.

---
 rtl/uart_rx_fifo.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver with mid-bit sampling, configurable frame format and a
//   first-word-fall-through receive FIFO with sticky error flags.
//
// Ports
//   clk         system clock, rising edge
//   clr         synchronous active-low reset
//   RxD         asynchronous serial input, idle high
//   rd_en       pop the head entry (ignored when empty)
//   err_clr     clear FE/PE/OE (a same-cycle set wins)
//   rx_data     head FIFO entry, 0 when empty
//   rdrf        FIFO not empty
//   fifo_count  number of valid entries
//   FE/PE/OE    sticky framing / parity / overrun flags
//
// Pop handshake: rdrf is the valid, rd_en is the ready; an entry leaves the
// FIFO on a rising edge where both are high. rd_en while rdrf=0 is a no-op.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          RxD,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rdrf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          FE,
    output logic                          PE,
    output logic                          OE
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = 4;

    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    // Receiver state; 'state' is the observation point for the FSM.
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 par_bad, par_bad_n;
    logic                 push_req, set_fe;

    logic rx_meta, rxs;

    // FIFO storage
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [AW:0]          count;
    logic                 full, pop, wr, set_oe, set_pe;
    logic                 expire;

    // Two-flop synchroniser; resets to the idle level so reset never looks
    // like a start bit.
    always_ff @(posedge clk) begin
        if (!clr) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    assign expire = (cnt == '0);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        push_req  = 1'b0;
        set_fe    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    cnt_n   = HALF_BIT;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else if (rxs) begin
                    state_n = S_IDLE;   // glitch, not a real start bit
                end else begin
                    cnt_n     = FULL_BIT;
                    bit_idx_n = '0;
                    par_bad_n = 1'b0;
                    state_n   = S_DATA;
                end
            end
            S_DATA: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    // LSB arrives first and ends up in bit 0 after DATA_BITS shifts
                    shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                    cnt_n   = FULL_BIT;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_n = '0;
                        state_n   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_bad_n = (PARITY == 1) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
                    cnt_n     = FULL_BIT;
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (!expire) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n = FULL_BIT;
                    if (!rxs) begin
                        set_fe  = 1'b1;
                        state_n = S_WAIT_IDLE;
                    end else if (bit_idx == LAST_STOP) begin
                        push_req = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_WAIT_IDLE: begin
                // Held-low line (break) yields one FE, then waits for idle.
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par_bad <= par_bad_n;
        end
    end

    // A full FIFO still accepts the frame when the head is popped in the
    // same cycle.
    assign full   = (count == DEPTH);
    assign pop    = rd_en && (count != '0);
    assign wr     = push_req && (!full || rd_en);
    assign set_oe = push_req && full && !rd_en;
    assign set_pe = wr && par_bad;

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            FE    <= 1'b0;
            PE    <= 1'b0;
            OE    <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            FE <= set_fe | (FE & ~err_clr);
            PE <= set_pe | (PE & ~err_clr);
            OE <= set_oe | (OE & ~err_clr);
        end
    end

    assign rx_data    = (count == '0) ? '0 : mem[rptr];
    assign rdrf       = (count != '0);
    assign fifo_count = count;

endmodule
